// File: rtl/recon_pkg.sv
// Shared types and constants for the quot*rop+mod dividend reconstruction block.
package recon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } recon_state_t;

   localparam int DEF_WIDTH = 8;

   // The counter must reach WIDTH itself, hence the extra bit.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/recon_shift_add_step.sv
// One shift-and-add step: adds rop<<idx to the accumulator when the quot bit is set.
module recon_shift_add_step
   import recon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CW    = cnt_width(DEF_WIDTH)
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   rop,
   input  logic               quot_bit,
   input  logic [CW-1:0]      idx,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [2*WIDTH-1:0] rop_ext_s;

   assign rop_ext_s = {{WIDTH{1'b0}}, rop};
   assign acc_next  = quot_bit ? (acc + (rop_ext_s << idx)) : acc;

endmodule

// File: rtl/recon_multiplier8.sv
// Sequential reconstruction of a dividend as quot*rop+mod, one quot bit per cycle.
// Defining RECON_CHECK_EN adds the mod>=rop consistency flag on err.
module recon_multiplier8
   import recon_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   quot,
   input  logic [WIDTH-1:0]   rop,
   input  logic [WIDTH-1:0]   mod,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] lop,
   output logic               ovf,
   output logic               err
);

   localparam int CW = cnt_width(WIDTH);

   recon_state_t       state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rop_q, rop_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [2*WIDTH-1:0] step_acc_s;

   recon_shift_add_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
      .acc      (acc_q),
      .rop      (rop_q),
      .quot_bit (quot_q[0]),
      .idx      (cnt_q),
      .acc_next (step_acc_s)
   );

   // Next-state, datapath and overflow flag
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rop_d   = rop_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               quot_d  = quot;
               rop_d   = rop;
               acc_d   = {{WIDTH{1'b0}}, mod};
               cnt_d   = {CW{1'b0}};
               ovf_d   = 1'b0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // quot is shifted down so bit 0 is always the current bit
            acc_d  = step_acc_s;
            quot_d = quot_q >> 1;
            cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(WIDTH - 1)) begin
               ovf_d   = |step_acc_s[2*WIDTH-1:WIDTH];
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         quot_q  <= {WIDTH{1'b0}};
         rop_q   <= {WIDTH{1'b0}};
         acc_q   <= {(2*WIDTH){1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rop_q   <= rop_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign lop       = acc_q;
   assign ovf       = ovf_q;

`ifdef RECON_CHECK_EN
   logic err_q, err_d;

   // Consistency flag captured with the operands; rop=0 always flags
   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && in_valid) begin
         err_d = (mod >= rop);
      end else begin
         err_d = err_q;
      end
   end

   // Consistency flag register
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_recon_multiplier8.sv
// Self-checking bench for recon_multiplier8: vector table, scoreboard queue, corner sequences.
module tb_recon_multiplier8;

   localparam int W = 8;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   quot;
   logic [W-1:0]   rop;
   logic [W-1:0]   mod;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] lop;
   logic           ovf;
   logic           err;

   typedef struct {
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      logic [W-1:0]   m;
      logic [2*W-1:0] lop;
      logic           ovf;
   } vec_t;

   typedef struct {
      logic [2*W-1:0] lop;
      logic           ovf;
      logic           err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   recon_multiplier8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quot      (quot),
      .rop       (rop),
      .mod       (mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lop       (lop),
      .ovf       (ovf),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic exp_err(input logic [W-1:0] r, input logic [W-1:0] m);
`ifdef RECON_CHECK_EN
      return (m >= r);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, presents operands for one accepting edge, then scrambles the inputs.
   task automatic accept_op(input logic [W-1:0] q, input logic [W-1:0] r, input logic [W-1:0] m,
                            input logic [2*W-1:0] e_lop);
      exp_t e;
      int   cyc = 0;
      while (!in_ready && cyc < 40) begin
         tick();
         cyc++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      quot     = q;
      rop      = r;
      mod      = m;
      e.lop    = e_lop;
      e.ovf    = |e_lop[2*W-1:W];
      e.err    = exp_err(r, m);
      sb.push_back(e);
      tick();
      quot = W'($urandom);
      rop  = W'($urandom);
      mod  = W'($urandom);
   endtask

   // Waits for out_valid, checks latency and the popped expectation, then consumes the result.
   task automatic collect(input string name);
      exp_t e;
      int   cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check({name, "_latency"}, 32'(cyc), 32'd8);
      if (sb.size() == 0) begin
         check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, "_lop"}, 32'(lop), 32'(e.lop));
         check({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
         check({name, "_err"}, 32'(err), 32'(e.err));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_idle_after_consume"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      vec_t vecs[$];
      logic [2*W-1:0] held_lop;
      logic           held_ovf;
      logic           held_err;
      logic [W-1:0]   rq, rr, rm;

      vecs.push_back('{q: 8'd1,   r: 8'd3,   m: 8'd2,   lop: 16'd5,     ovf: 1'b0});
      vecs.push_back('{q: 8'd3,   r: 8'd13,  m: 8'd6,   lop: 16'd45,    ovf: 1'b0});
      vecs.push_back('{q: 8'd4,   r: 8'd5,   m: 8'd0,   lop: 16'd20,    ovf: 1'b0});
      vecs.push_back('{q: 8'd255, r: 8'd255, m: 8'd254, lop: 16'd65279, ovf: 1'b1});
      vecs.push_back('{q: 8'd1,   r: 8'd3,   m: 8'd5,   lop: 16'd8,     ovf: 1'b0});
      vecs.push_back('{q: 8'd0,   r: 8'd77,  m: 8'd9,   lop: 16'd9,     ovf: 1'b0});
      vecs.push_back('{q: 8'd200, r: 8'd0,   m: 8'd3,   lop: 16'd3,     ovf: 1'b0});
      vecs.push_back('{q: 8'd16,  r: 8'd16,  m: 8'd15,  lop: 16'd271,   ovf: 1'b1});
      vecs.push_back('{q: 8'd128, r: 8'd2,   m: 8'd1,   lop: 16'd257,   ovf: 1'b1});
      vecs.push_back('{q: 8'd85,  r: 8'd3,   m: 8'd0,   lop: 16'd255,   ovf: 1'b0});

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      quot      = 8'd0;
      rop       = 8'd0;
      mod       = 8'd0;
      tick();
      tick();
      reset = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_lop", 32'(lop), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_err", 32'(err), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         accept_op(vecs[i].q, vecs[i].r, vecs[i].m, vecs[i].lop);
         collect($sformatf("vec%0d", i));
         check($sformatf("vec%0d_table_ovf", i), 32'(|vecs[i].lop[2*W-1:W]), 32'(vecs[i].ovf));
      end

      for (int i = 0; i < 6; i++) begin
         rq = W'($urandom);
         rr = W'($urandom);
         rm = W'($urandom);
         accept_op(rq, rr, rm, (2*W)'(rq) * (2*W)'(rr) + (2*W)'(rm));
         collect($sformatf("rand%0d", i));
      end

      // Backpressure: result held for three cycles, new in_valid ignored.
      accept_op(8'd3, 8'd13, 8'd6, 16'd45);
      for (int c = 0; c < 40 && !out_valid; c++) tick();
      in_valid = 1'b0;
      held_lop = lop;
      held_ovf = ovf;
      held_err = err;
      check("hold_initial_lop", 32'(held_lop), 32'd45);
      in_valid = 1'b1;
      quot     = 8'd9;
      rop      = 8'd9;
      mod      = 8'd9;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("hold%0d_lop", c), 32'(lop), 32'(held_lop));
         check($sformatf("hold%0d_ovf_err", c), {30'd0, ovf, err}, {30'd0, held_ovf, held_err});
         check($sformatf("hold%0d_valid_ready", c), {30'd0, out_valid, in_ready}, 32'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
      void'(sb.pop_front());

      // Reset in the fourth BUSY cycle abandons the operation.
      accept_op(8'd90, 8'd51, 8'd1, 16'd4591);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("busy_reset_in_ready", 32'(in_ready), 32'd1);
      check("busy_reset_out_valid", 32'(out_valid), 32'd0);
      check("busy_reset_lop", 32'(lop), 32'd0);
      sb.delete();
      tick();
      check("busy_reset_no_result", 32'(out_valid), 32'd0);
      accept_op(8'd1, 8'd3, 8'd2, 16'd5);
      collect("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
